// File: rtl/mod_counter_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mod_counter_gen_if
// Description : Control/status bundle for the modulo-N counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mod_counter_gen_if #(
    parameter int WIDTH = 8,
    parameter int EVW   = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ev_clr;
    logic [WIDTH-1:0] count;
    logic             rollover;
    logic             underflow;
    logic             sat;
    logic             tc;
    logic [EVW-1:0]   events;

    modport master (
        output en, up, clr, load, din, ev_clr,
        input  count, rollover, underflow, sat, tc, events
    );

    modport slave (
        input  en, up, clr, load, din, ev_clr,
        output count, rollover, underflow, sat, tc, events
    );
endinterface
`default_nettype wire

// File: rtl/mod_counter_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mod_counter_gen
// Description : Modulo-N up/down counter with clear, load, wrap/saturate,
//               pulse flags, cascade terminal count and a wrap-event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter_gen #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 20,
    parameter int SATURATE = 0,
    parameter int EVW      = 4
) (
    input  wire               clk,
    input  wire               resetn,
    mod_counter_gen_if.slave  bus
);
    localparam logic [WIDTH-1:0] c_MAX    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   c_MOD    = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_ONE    = WIDTH'(1);
    localparam logic [EVW-1:0]   c_EV_MAX = '1;
    localparam logic [EVW-1:0]   c_EV_ONE = EVW'(1);
    localparam bit               c_SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_rollover;
    logic             r_underflow;
    logic             r_sat;
    logic [EVW-1:0]   r_events;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_roll_nxt;
    logic             w_under_nxt;
    logic             w_sat_nxt;
    logic [EVW-1:0]   w_events_nxt;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_din_over;

    assign w_at_top   = (r_count == c_MAX);
    assign w_at_bot   = (r_count == '0);
    // Widened compare so MODULUS == 2**WIDTH never clamps.
    assign w_din_over = ({1'b0, bus.din} >= c_MOD);

    always_comb begin
        w_count_nxt = r_count;
        w_roll_nxt  = 1'b0;
        w_under_nxt = 1'b0;
        w_sat_nxt   = 1'b0;
        if (bus.clr) begin
            w_count_nxt = '0;
        end else if (bus.load) begin
            w_count_nxt = w_din_over ? c_MAX : bus.din;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!w_at_top) begin
                    w_count_nxt = r_count + c_ONE;
                end else if (c_SAT) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    w_count_nxt = '0;
                    w_roll_nxt  = 1'b1;
                end
            end else begin
                if (!w_at_bot) begin
                    w_count_nxt = r_count - c_ONE;
                end else if (c_SAT) begin
                    w_sat_nxt = 1'b1;
                end else begin
                    w_count_nxt = c_MAX;
                    w_under_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_events_nxt = r_events;
        if (bus.ev_clr) begin
            w_events_nxt = '0;
        end else if ((w_roll_nxt || w_under_nxt) && (r_events != c_EV_MAX)) begin
            w_events_nxt = r_events + c_EV_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count     <= '0;
            r_rollover  <= 1'b0;
            r_underflow <= 1'b0;
            r_sat       <= 1'b0;
            r_events    <= '0;
        end else begin
            r_count     <= w_count_nxt;
            r_rollover  <= w_roll_nxt;
            r_underflow <= w_under_nxt;
            r_sat       <= w_sat_nxt;
            r_events    <= w_events_nxt;
        end
    end

    // Zero-latency terminal count feeds the next stage's enable.
    assign bus.tc        = bus.en & ((bus.up & w_at_top) | (~bus.up & w_at_bot));
    assign bus.count     = r_count;
    assign bus.rollover  = r_rollover;
    assign bus.underflow = r_underflow;
    assign bus.sat       = r_sat;
    assign bus.events    = r_events;
endmodule
`default_nettype wire

// File: tb/tb_mod_counter_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter_gen
// Description : Self-checking bench for mod_counter_gen (wrap, saturate, cascade).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter_gen;
    localparam int MOD = 20;
    localparam int EVMAX = 15;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic d_en, d_up, d_clr, d_load, d_evclr, c_en;
    logic [7:0] d_din;

    mod_counter_gen_if #(.WIDTH(8), .EVW(4)) ifw ();
    mod_counter_gen_if #(.WIDTH(8), .EVW(4)) ifs ();
    mod_counter_gen_if #(.WIDTH(8), .EVW(4)) ifl ();
    mod_counter_gen_if #(.WIDTH(8), .EVW(4)) ifh ();

    assign ifw.en = d_en;   assign ifw.up = d_up;   assign ifw.clr = d_clr;
    assign ifw.load = d_load; assign ifw.din = d_din; assign ifw.ev_clr = d_evclr;
    assign ifs.en = d_en;   assign ifs.up = d_up;   assign ifs.clr = d_clr;
    assign ifs.load = d_load; assign ifs.din = d_din; assign ifs.ev_clr = d_evclr;
    assign ifl.en = c_en;   assign ifl.up = 1'b1;   assign ifl.clr = 1'b0;
    assign ifl.load = 1'b0; assign ifl.din = 8'd0;  assign ifl.ev_clr = 1'b0;
    assign ifh.en = ifl.tc; assign ifh.up = 1'b1;   assign ifh.clr = 1'b0;
    assign ifh.load = 1'b0; assign ifh.din = 8'd0;  assign ifh.ev_clr = 1'b0;

    mod_counter_gen #(.WIDTH(8), .MODULUS(20), .SATURATE(0), .EVW(4)) u_wrap (.clk(clk), .resetn(resetn), .bus(ifw));
    mod_counter_gen #(.WIDTH(8), .MODULUS(20), .SATURATE(1), .EVW(4)) u_sat  (.clk(clk), .resetn(resetn), .bus(ifs));
    mod_counter_gen #(.WIDTH(8), .MODULUS(20), .SATURATE(0), .EVW(4)) u_low  (.clk(clk), .resetn(resetn), .bus(ifl));
    mod_counter_gen #(.WIDTH(8), .MODULUS(20), .SATURATE(0), .EVW(4)) u_high (.clk(clk), .resetn(resetn), .bus(ifh));

    wire [15:0] v_w = {ifw.count, ifw.rollover, ifw.underflow, ifw.sat, ifw.tc, ifw.events};
    wire [15:0] v_s = {ifs.count, ifs.rollover, ifs.underflow, ifs.sat, ifs.tc, ifs.events};

    // Reference model: index 0 = wrap instance, 1 = saturate instance.
    int m_cnt[2], m_ro[2], m_uf[2], m_sat[2], m_ev[2];
    int n_pass = 0;
    int n_total = 0;

    task automatic model_zero();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ro[k] = 0; m_uf[k] = 0; m_sat[k] = 0; m_ev[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit ev;
            ev = 1'b0;
            m_ro[k] = 0; m_uf[k] = 0; m_sat[k] = 0;
            if (d_clr) begin
                m_cnt[k] = 0;
            end else if (d_load) begin
                m_cnt[k] = (int'(d_din) >= MOD) ? MOD - 1 : int'(d_din);
            end else if (d_en && d_up) begin
                if (m_cnt[k] + 1 < MOD) m_cnt[k] = m_cnt[k] + 1;
                else if (k == 1) m_sat[k] = 1;
                else begin m_cnt[k] = 0; m_ro[k] = 1; ev = 1'b1; end
            end else if (d_en) begin
                if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
                else if (k == 1) m_sat[k] = 1;
                else begin m_cnt[k] = MOD - 1; m_uf[k] = 1; ev = 1'b1; end
            end
            if (d_evclr) m_ev[k] = 0;
            else if (ev && m_ev[k] < EVMAX) m_ev[k] = m_ev[k] + 1;
        end
    endtask

    function automatic logic [15:0] exp_vec(int k);
        logic tc;
        tc = d_en && (d_up ? (m_cnt[k] == MOD - 1) : (m_cnt[k] == 0));
        return {8'(m_cnt[k]), 1'(m_ro[k]), 1'(m_uf[k]), 1'(m_sat[k]), tc, 4'(m_ev[k])};
    endfunction

    task automatic cyc(input logic en, input logic up, input logic clr,
                       input logic load, input logic [7:0] din, input logic evclr);
        d_en = en; d_up = up; d_clr = clr; d_load = load; d_din = din; d_evclr = evclr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        d_en = 0; d_up = 0; d_clr = 0; d_load = 0; d_din = 0; d_evclr = 0; c_en = 0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        model_zero();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (v_w !== 16'h0) $display("FAIL reset_wrap: got %h want 0000", v_w); else n_pass++;
        n_total++; if (v_s !== 16'h0) $display("FAIL reset_sat: got %h want 0000", v_s); else n_pass++;
        n_total++; if ({ifl.count, ifh.count} !== 16'h0) $display("FAIL reset_cascade: got %h/%h want 0/0", ifl.count, ifh.count); else n_pass++;
    endtask

    task automatic test_count_up();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 0, 8'd0, 0);
            n_total++; if (ifw.count !== 8'((i + 1) % MOD) || ifw.rollover !== (i == 19))
                $display("FAIL count_up[%0d]: got cnt=%0d ro=%b want cnt=%0d ro=%b", i, ifw.count, ifw.rollover, (i + 1) % MOD, i == 19);
            else n_pass++;
        end
        n_total++; if (ifw.events !== 4'd1) $display("FAIL count_up_events: got %0d want 1", ifw.events); else n_pass++;
        cyc(0, 1, 0, 0, 8'd0, 0);
        n_total++; if (ifw.rollover !== 1'b0 || ifw.count !== 8'd0) $display("FAIL rollover_pulse: got ro=%b cnt=%0d want 0/0", ifw.rollover, ifw.count); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        cyc(1, 0, 0, 0, 8'd0, 0);
        n_total++; if (ifw.count !== 8'd19 || ifw.underflow !== 1'b1) $display("FAIL underflow: got cnt=%0d uf=%b want 19/1", ifw.count, ifw.underflow); else n_pass++;
        n_total++; if (v_w !== exp_vec(0)) $display("FAIL underflow_vec: got %h want %h", v_w, exp_vec(0)); else n_pass++;
        cyc(0, 0, 0, 0, 8'd0, 0);
        n_total++; if (ifw.count !== 8'd19 || ifw.underflow !== 1'b0) $display("FAIL underflow_pulse: got cnt=%0d uf=%b want 19/0", ifw.count, ifw.underflow); else n_pass++;
    endtask

    task automatic test_load_clr();
        do_reset();
        cyc(0, 1, 0, 1, 8'd25, 0);
        n_total++; if (ifw.count !== 8'd19) $display("FAIL load_clamp: got %0d want 19", ifw.count); else n_pass++;
        cyc(1, 1, 0, 1, 8'd7, 0);
        n_total++; if (ifw.count !== 8'd7) $display("FAIL load_over_en: got %0d want 7", ifw.count); else n_pass++;
        cyc(1, 1, 1, 1, 8'd25, 0);
        n_total++; if (ifw.count !== 8'd0) $display("FAIL clr_wins: got %0d want 0", ifw.count); else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        cyc(0, 1, 0, 1, 8'd18, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 8'd0, 0);
            n_total++; if (ifs.count !== 8'd19 || ifs.sat !== (i >= 1) || ifs.rollover !== 1'b0 || ifs.tc !== 1'b1)
                $display("FAIL saturate[%0d]: got cnt=%0d sat=%b ro=%b tc=%b want 19/%b/0/1", i, ifs.count, ifs.sat, ifs.rollover, ifs.tc, i >= 1);
            else n_pass++;
            n_total++; if (v_w !== exp_vec(0)) $display("FAIL sat_wrap_peer[%0d]: got %h want %h", i, v_w, exp_vec(0)); else n_pass++;
        end
        cyc(1, 0, 0, 0, 8'd0, 0);
        n_total++; if (v_s !== exp_vec(1)) $display("FAIL sat_dir_change: got %h want %h", v_s, exp_vec(1)); else n_pass++;
    endtask

    task automatic test_cascade();
        int pulses;
        pulses = 0;
        do_reset();
        c_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (ifh.rollover === 1'b1) pulses++;
            if (i == 398) begin
                n_total++; if (ifl.count !== 8'd19 || ifh.count !== 8'd19 || ifh.tc !== 1'b1)
                    $display("FAIL cascade_19_19: got %0d/%0d tc=%b want 19/19/1", ifl.count, ifh.count, ifh.tc);
                else n_pass++;
            end
        end
        c_en = 1'b0;
        n_total++; if (ifl.count !== 8'd0 || ifh.count !== 8'd0) $display("FAIL cascade_end: got %0d/%0d want 0/0", ifl.count, ifh.count); else n_pass++;
        n_total++; if (pulses != 1) $display("FAIL cascade_pulses: got %0d want 1", pulses); else n_pass++;
        n_total++; if (ifl.events !== 4'd15 || ifh.events !== 4'd1) $display("FAIL cascade_events: got %0d/%0d want 15/1", ifl.events, ifh.events); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 67; i++) cyc(1, 1, 0, 0, 8'd0, 0);
        n_total++; if (ifw.count !== 8'd7 || ifw.events !== 4'd3) $display("FAIL pre_reset: got cnt=%0d ev=%0d want 7/3", ifw.count, ifw.events); else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_total++; if (v_w !== 16'h0 || v_s !== 16'h0) $display("FAIL async_reset: got %h/%h want 0000/0000", v_w, v_s); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (v_w !== 16'h0 || v_s !== 16'h0) $display("FAIL reset_hold: got %h/%h want 0000/0000", v_w, v_s); else n_pass++;
        model_zero();
        resetn = 1'b1;
    endtask

    task automatic test_ev_clr();
        do_reset();
        for (int i = 0; i < 320; i++) begin
            cyc(1, 1, 0, 0, 8'd0, 1);
            if (i % 20 == 19) begin
                n_total++; if (ifw.events !== 4'd0 || ifw.rollover !== 1'b1) $display("FAIL ev_clr_hold[%0d]: got ev=%0d ro=%b want 0/1", i, ifw.events, ifw.rollover); else n_pass++;
            end
        end
        for (int i = 0; i < 400; i++) cyc(1, 1, 0, 0, 8'd0, 0);
        n_total++; if (ifw.events !== 4'd15) $display("FAIL events_sat: got %0d want 15", ifw.events); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom % 2), $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) == 0, ($urandom % 2) ? 8'($urandom_range(0, 31)) : 8'($urandom),
                $urandom_range(0, 29) == 0);
            n_total++; if (v_w !== exp_vec(0)) $display("FAIL rand_wrap[%0d]: got %h want %h", i, v_w, exp_vec(0)); else n_pass++;
            n_total++; if (v_s !== exp_vec(1)) $display("FAIL rand_sat[%0d]: got %h want %h", i, v_s, exp_vec(1)); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_underflow();
        test_load_clr();
        test_saturate();
        test_cascade();
        test_async_reset();
        test_ev_clr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
